// File: rtl/prob_adjust_gen.sv
// ============================================================================
// Module   : prob_adjust_gen
// Purpose  : LFSR-driven local/global move decision generator with a
//            valid/ready handshake and windowed statistics of local decisions.
//            Define PROB_ADJUST_ADAPT_EN for the adaptive threshold variant.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prob_adjust_gen #(
    parameter int W        = 16,
    parameter int WIN_LOG2 = 6,
    parameter int STEP     = 1
) (
    input  logic                in_clock,
    input  logic                in_reset_n,
    input  logic                in_seed_load,
    input  logic [W-1:0]        in_seed,
    input  logic [W-1:0]        in_Pls,
    input  logic                in_enable,
    input  logic                in_ready,
`ifdef PROB_ADJUST_ADAPT_EN
    input  logic [WIN_LOG2:0]   in_target_count,
`endif
    output logic                out_valid,
    output logic                out_is_local,
    output logic                out_window_done,
    output logic [WIN_LOG2:0]   out_local_count,
    output logic [W-1:0]        out_threshold
);

    localparam logic [31:0] C_TAPS_ALL = (W == 8)  ? 32'h0000_00B8 :
                                         (W == 16) ? 32'h0000_B400 :
                                                     32'h8020_0003;
    localparam logic [W-1:0]        C_TAPS     = C_TAPS_ALL[W-1:0];
    localparam logic [W-1:0]        C_ONES     = '1;
    localparam logic [WIN_LOG2-1:0] C_WIN_LAST = '1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_produce;
    logic                w_handshake;
    logic                w_win_end;
    logic [W-1:0]        r_lfsr;
    logic [W-1:0]        w_lfsr_next;
    logic [W-1:0]        w_seed_safe;
    logic [W-1:0]        r_thr;
    logic [W-1:0]        w_thr_next;
    logic                r_valid;
    logic                r_is_local;
    logic                r_window_done;
    logic [WIN_LOG2:0]   r_local_count;
    logic [WIN_LOG2-1:0] r_win_cnt;
    logic [WIN_LOG2:0]   r_loc_cnt;
    logic [WIN_LOG2:0]   w_loc_total;

    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? C_TAPS : '0);
    assign w_seed_safe = (in_seed == '0) ? C_ONES : in_seed;
    assign w_handshake = r_valid & in_ready & ~in_seed_load;
    assign w_loc_total = r_loc_cnt + (WIN_LOG2+1)'(r_is_local);
    assign w_win_end   = w_handshake && (r_win_cnt == C_WIN_LAST);

    always_comb begin
        w_state_next = r_state;
        w_produce    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_enable) begin
                    w_produce    = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (in_ready) begin
                    if (in_enable) begin
                        w_produce = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // Soft restart discards any pending or newly requested decision.
        if (in_seed_load) begin
            w_produce    = 1'b0;
            w_state_next = S_IDLE;
        end
    end

`ifdef PROB_ADJUST_ADAPT_EN
    localparam logic [W:0] C_STEP_EXT = (W+1)'(STEP);
    logic [W:0] w_thr_up;
    assign w_thr_up = {1'b0, r_thr} + C_STEP_EXT;

    always_comb begin
        w_thr_next = r_thr;
        if (in_seed_load) begin
            w_thr_next = in_Pls;
        end else if (w_win_end) begin
            if (w_loc_total < in_target_count) begin
                w_thr_next = w_thr_up[W] ? C_ONES : w_thr_up[W-1:0];
            end else if (w_loc_total > in_target_count) begin
                w_thr_next = ({1'b0, r_thr} < C_STEP_EXT) ? '0 : r_thr - C_STEP_EXT[W-1:0];
            end
        end
    end
`else
    always_comb begin
        w_thr_next = in_Pls;
    end
`endif

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_lfsr        <= C_ONES;
            r_thr         <= '0;
            r_valid       <= 1'b0;
            r_is_local    <= 1'b0;
            r_window_done <= 1'b0;
            r_local_count <= '0;
            r_win_cnt     <= '0;
            r_loc_cnt     <= '0;
        end else begin
            r_thr   <= w_thr_next;
            r_valid <= (w_state_next == S_HOLD);
            if (in_seed_load) begin
                r_lfsr        <= w_seed_safe;
                r_window_done <= 1'b0;
                r_win_cnt     <= '0;
                r_loc_cnt     <= '0;
            end else begin
                r_window_done <= w_win_end;
                if (w_produce) begin
                    r_lfsr     <= w_lfsr_next;
                    r_is_local <= (w_lfsr_next < r_thr);
                end
                if (w_win_end) begin
                    r_local_count <= w_loc_total;
                    r_win_cnt     <= '0;
                    r_loc_cnt     <= '0;
                end else if (w_handshake) begin
                    r_win_cnt <= r_win_cnt + 1'b1;
                    r_loc_cnt <= w_loc_total;
                end
            end
        end
    end

    assign out_valid       = r_valid;
    assign out_is_local    = r_is_local;
    assign out_window_done = r_window_done;
    assign out_local_count = r_local_count;
    assign out_threshold   = r_thr;

endmodule

`default_nettype wire

// File: tb/tb_prob_adjust_gen.sv
// ============================================================================
// Module   : tb_prob_adjust_gen
// Purpose  : Self-checking bench for prob_adjust_gen (W=8, 4-decision window).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prob_adjust_gen;

    localparam int W      = 8;
    localparam int WL     = 2;
    localparam int STEP_P = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          seed_load = 1'b0;
    logic [W-1:0]  seed = '0;
    logic [W-1:0]  pls = '0;
    logic          enable = 1'b0;
    logic          ready = 1'b0;
`ifdef PROB_ADJUST_ADAPT_EN
    logic [WL:0]   target = 3'd2;
`endif
    logic          valid;
    logic          is_local;
    logic          win_done;
    logic [WL:0]   loc_count;
    logic [W-1:0]  threshold;

    prob_adjust_gen #(.W(W), .WIN_LOG2(WL), .STEP(STEP_P)) dut (
        .in_clock        (clk),
        .in_reset_n      (rst_n),
        .in_seed_load    (seed_load),
        .in_seed         (seed),
        .in_Pls          (pls),
        .in_enable       (enable),
        .in_ready        (ready),
`ifdef PROB_ADJUST_ADAPT_EN
        .in_target_count (target),
`endif
        .out_valid       (valid),
        .out_is_local    (is_local),
        .out_window_done (win_done),
        .out_local_count (loc_count),
        .out_threshold   (threshold)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Transaction-level reference state
    int m_lfsr, m_thr, m_win, m_loc, m_cnt;
    bit m_valid, m_local, m_done;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lfsr_step(input int x);
        return (x >> 1) ^ (((x & 1) != 0) ? 'hB8 : 0);
    endfunction

    task automatic model_reset();
        m_lfsr = 255; m_thr = 0; m_win = 0; m_loc = 0; m_cnt = 0;
        m_valid = 0; m_local = 0; m_done = 0;
    endtask

    task automatic model_edge();
        bit hs, prod;
        int tot;
        if (!rst_n) begin
            model_reset();
        end else if (seed_load) begin
            m_lfsr  = (seed == 0) ? 255 : int'(seed);
            m_valid = 0; m_win = 0; m_loc = 0; m_done = 0;
            m_thr   = int'(pls);
        end else begin
            hs   = m_valid && ready;
            prod = enable && (!m_valid || ready);
            m_done = 0;
            tot = 0;
            if (hs) begin
                tot = m_loc + int'(m_local);
                if (m_win + 1 == (1 << WL)) begin
                    m_cnt = tot; m_done = 1; m_win = 0; m_loc = 0;
                end else begin
                    m_win = m_win + 1; m_loc = tot;
                end
            end
            if (prod) begin
                m_lfsr  = lfsr_step(m_lfsr);
                m_local = (m_lfsr < m_thr);
                m_valid = 1;
            end else if (hs) begin
                m_valid = 0;
            end
`ifdef PROB_ADJUST_ADAPT_EN
            if (m_done) begin
                if (tot < int'(target))      m_thr = (m_thr + STEP_P > 255) ? 255 : m_thr + STEP_P;
                else if (tot > int'(target)) m_thr = (m_thr < STEP_P) ? 0 : m_thr - STEP_P;
            end
`else
            m_thr = int'(pls);
`endif
        end
    endtask

    task automatic check_all(input string tag);
        cmp({tag, "_valid"}, 32'(valid), 32'(m_valid));
        cmp({tag, "_local"}, 32'(is_local), 32'(m_local));
        cmp({tag, "_done"}, 32'(win_done), 32'(m_done));
        cmp({tag, "_count"}, 32'(loc_count), 32'(m_cnt));
        cmp({tag, "_thr"}, 32'(threshold), 32'(m_thr));
    endtask

    task automatic drive(input bit sl, input logic [W-1:0] sd, input logic [W-1:0] p,
                         input bit en, input bit rd);
        seed_load = sl; seed = sd; pls = p; enable = en; ready = rd;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    typedef struct {
        bit         sl;
        logic [7:0] sd;
        logic [7:0] p;
        bit         en;
        bit         rd;
        bit         ev;
        bit         el;
    } vec_t;

    vec_t tbl[6];
    int   done_seen;

    initial begin
        // Seed 7 steps to 0xBB (187): below 200, not below 50.
        tbl[0] = '{1, 8'd7, 8'd50,  0, 0, 0, 0};
        tbl[1] = '{0, 8'd0, 8'd50,  1, 0, 1, 0};
        tbl[2] = '{0, 8'd0, 8'd50,  0, 1, 0, 0};
        tbl[3] = '{1, 8'd7, 8'd200, 0, 0, 0, 0};
        tbl[4] = '{0, 8'd0, 8'd200, 1, 0, 1, 1};
        tbl[5] = '{0, 8'd0, 8'd200, 0, 1, 0, 1};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].sl, tbl[i].sd, tbl[i].p, tbl[i].en, tbl[i].rd);
            cycle("tbl");
            cmp("tbl_vec_valid", 32'(valid), 32'(tbl[i].ev));
            cmp("tbl_vec_local", 32'(is_local), 32'(tbl[i].el));
        end

        // Stall in HOLD for five cycles with ready low
        drive(1, 8'h5A, 8'd128, 0, 0); cycle("hold_seed");
        drive(0, 8'h00, 8'd128, 1, 0); cycle("hold_first");
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'h00, 8'($urandom), 1'($urandom), 0);
            cycle("hold_stall");
            cmp("hold_valid", 32'(valid), 32'd1);
        end

        // Zero seed then a full LFSR period back-to-back with random thresholds
        drive(1, 8'h00, 8'd128, 0, 1); cycle("period_seed");
        for (int i = 0; i < 256; i++) begin
            drive(0, 8'h00, 8'($urandom), 1, 1);
            cycle("period");
        end

        // Windows: threshold 0 (all global) then all-ones (mostly local)
        drive(1, 8'h01, 8'd0, 0, 0); cycle("win_seed");
        done_seen = 0;
        for (int i = 0; i < 9; i++) begin
            drive(0, 8'h00, 8'd0, 1, 1);
            cycle("win_zero");
            if (win_done) begin
                done_seen++;
                cmp("win_zero_count", 32'(loc_count), 32'd0);
            end
        end
        cmp("win_zero_windows", 32'(done_seen), 32'd2);
        drive(1, 8'h01, 8'd255, 0, 0); cycle("win_ones_seed");
        for (int i = 0; i < 9; i++) begin
            drive(0, 8'h00, 8'd255, 1, 1);
            cycle("win_ones");
        end

        // Seed load during HOLD with ready high overrides the handshake
        drive(0, 8'h00, 8'd255, 1, 0); cycle("sl_hold_a");
        drive(1, 8'h33, 8'd255, 1, 1); cycle("sl_hold_b");
        cmp("sl_hold_valid", 32'(valid), 32'd0);

        // Asynchronous reset in the middle of HOLD
        drive(0, 8'h00, 8'd255, 1, 0); cycle("rst_hold_a");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        cmp("rst_async_valid", 32'(valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 60) == 0, 8'($urandom), 8'($urandom),
                  ($urandom % 4) != 0, ($urandom % 3) != 0);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
